// File: rtl/accum_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_readout_pkg
// Description : Shared Hough-accumulator constants used by the readout block
//               and its sub-modules.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_readout_pkg;

    // Accumulator geometry
    localparam int c_RHO_RANGE        = 2939;
    localparam int c_THETAS           = 180;
    localparam int c_RHOS             = 1469;
    localparam int c_ACCUM_BUFF_WIDTH = 16;

    // Widths of the rho/theta tags that travel with every word
    localparam int c_RHO_OUT_W        = 16;
    localparam int c_THETA_OUT_W      = 8;

endpackage
`default_nettype wire

// File: rtl/accum_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : accum_skid_buf
// Description : Two-entry FIFO that absorbs BRAM read latency so the readout
//               can keep streaming while the downstream FIFO stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_skid_buf
    import accum_readout_pkg::*;
#(
    parameter int WIDTH = c_ACCUM_BUFF_WIDTH + c_RHO_OUT_W + c_THETA_OUT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage, pointers and occupancy; the producer never pushes when full
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/accum_readout.sv
`default_nettype none
// ============================================================================
// Module      : accum_readout
// Description : Scans the whole Hough accumulator BRAM rho-major / theta-minor
//               and streams {value, signed rho, theta} into a downstream FIFO
//               with full back-pressure support.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_readout
    import accum_readout_pkg::*;
#(
    parameter int RHO_RANGE        = c_RHO_RANGE,
    parameter int THETAS           = c_THETAS,
    parameter int RHOS             = c_RHOS,
    parameter int ACCUM_BUFF_WIDTH = c_ACCUM_BUFF_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  accum_rd_en,
    output logic [$clog2(RHO_RANGE*THETAS)-1:0]   accum_rd_addr,
    input  logic [ACCUM_BUFF_WIDTH-1:0]           accum_rd_data,
    input  logic                                  out_full,
    output logic                                  out_wr_en,
    output logic [ACCUM_BUFF_WIDTH-1:0]           out_dout,
    output logic signed [c_RHO_OUT_W-1:0]         out_rho,
    output logic [c_THETA_OUT_W-1:0]              out_theta,
    output logic                                  busy,
    output logic                                  done
);

    localparam int c_TOTAL   = RHO_RANGE * THETAS;
    localparam int c_ADDR_W  = $clog2(c_TOTAL);
    localparam int c_ENTRY_W = ACCUM_BUFF_WIDTH + c_RHO_OUT_W + c_THETA_OUT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;

    // Scan position; address tracks rho_idx*THETAS + theta_idx incrementally
    logic [c_ADDR_W-1:0]            r_addr;
    logic [c_RHO_OUT_W-1:0]         r_rho_idx;
    logic [c_THETA_OUT_W-1:0]       r_theta_idx;

    // One BRAM read can be outstanding; its tags wait here for the data
    logic                           r_inflight;
    logic signed [c_RHO_OUT_W-1:0]  r_tag_rho;
    logic [c_THETA_OUT_W-1:0]       r_tag_theta;

    logic [c_ENTRY_W-1:0]           w_head;
    logic [1:0]                     w_count;
    logic                           w_empty;
    logic                           w_pop;
    logic [2:0]                     w_occ;
    logic                           w_issue;
    logic                           w_last;
    logic                           w_drained;

    // A slot freed by this cycle's pop is already available for a new read;
    // this keeps one word per cycle flowing with a two-entry buffer.
    assign w_pop     = !w_empty && !out_full;
    assign w_occ     = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue   = (r_state == READ) && (w_occ < 3'd2);
    assign w_last    = (r_addr == c_ADDR_W'(c_TOTAL - 1));
    // Buffer becomes empty this cycle and nothing is still coming from BRAM
    assign w_drained = !r_inflight &&
                       ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = READ;
            READ:    if (w_issue && w_last) w_state_next = DRAIN;
            DRAIN:   if (w_drained) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Scan counters: advance per issued read, rewind after the final address
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_rho_idx   <= '0;
            r_theta_idx <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_addr      <= '0;
            r_rho_idx   <= '0;
            r_theta_idx <= '0;
        end else if (w_issue) begin
            if (w_last) begin
                r_addr      <= '0;
                r_rho_idx   <= '0;
                r_theta_idx <= '0;
            end else begin
                r_addr <= r_addr + c_ADDR_W'(1);
                if (r_theta_idx == c_THETA_OUT_W'(THETAS - 1)) begin
                    r_theta_idx <= '0;
                    r_rho_idx   <= r_rho_idx + c_RHO_OUT_W'(1);
                end else begin
                    r_theta_idx <= r_theta_idx + c_THETA_OUT_W'(1);
                end
            end
        end
    end

    // Remember the issuing position so the returning word is tagged correctly
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_inflight  <= 1'b0;
            r_tag_rho   <= '0;
            r_tag_theta <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_rho   <= $signed(r_rho_idx - c_RHO_OUT_W'(RHOS));
                r_tag_theta <= r_theta_idx;
            end
        end
    end

    accum_skid_buf #(
        .WIDTH (c_ENTRY_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (r_inflight),
        .push_data ({accum_rd_data, r_tag_rho, r_tag_theta}),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    assign accum_rd_en                   = w_issue;
    assign accum_rd_addr                 = r_addr;
    assign out_wr_en                     = w_pop;
    assign {out_dout, out_rho, out_theta} = w_head;
    assign busy                          = (r_state == READ) || (r_state == DRAIN);
    assign done                          = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_accum_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_readout
// Description : Self-checking bench for accum_readout with a 3x4 accumulator
//               whose BRAM returns its own address as data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_readout;

    localparam int RHO_RANGE = 3;
    localparam int THETAS    = 4;
    localparam int RHOS      = 1;
    localparam int W         = 16;
    localparam int NWORDS    = RHO_RANGE * THETAS;
    localparam int BUDGET    = 60;

    logic              clock;
    logic              reset;
    logic              start;
    logic              accum_rd_en;
    logic [3:0]        accum_rd_addr;
    logic [W-1:0]      accum_rd_data;
    logic              out_full;
    logic              out_wr_en;
    logic [W-1:0]      out_dout;
    logic signed [15:0] out_rho;
    logic [7:0]        out_theta;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int data;
        int rho;
        int theta;
    } exp_t;

    exp_t sb[$];

    // Scenario record: stimulus (full window, extra start) and expected timing
    typedef struct {
        int full_lo;
        int full_hi;
        int restart_k;
        int exp_first;
        int exp_last;
        int exp_done;
        int exp_rd_win;
    } scen_t;

    scen_t scen[4];

    accum_readout #(
        .RHO_RANGE        (RHO_RANGE),
        .THETAS           (THETAS),
        .RHOS             (RHOS),
        .ACCUM_BUFF_WIDTH (W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .accum_rd_en   (accum_rd_en),
        .accum_rd_addr (accum_rd_addr),
        .accum_rd_data (accum_rd_data),
        .out_full      (out_full),
        .out_wr_en     (out_wr_en),
        .out_dout      (out_dout),
        .out_rho       (out_rho),
        .out_theta     (out_theta),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BRAM model: word = address, one cycle after the read strobe
    always @(posedge clock) begin
        if (accum_rd_en) accum_rd_data <= 16'(accum_rd_addr);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_sb();
        exp_t e;
        sb.delete();
        for (int i = 0; i < NWORDS; i++) begin
            e.data  = i;
            e.rho   = (i / THETAS) - RHOS;
            e.theta = i % THETAS;
            sb.push_back(e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"},   accum_rd_en,   0);
        chk({tag, "_rd_addr"}, accum_rd_addr, 0);
        chk({tag, "_wr_en"},   out_wr_en,     0);
        chk({tag, "_dout"},    out_dout,      0);
        chk({tag, "_rho"},     out_rho,       0);
        chk({tag, "_theta"},   out_theta,     0);
        chk({tag, "_busy"},    busy,          0);
        chk({tag, "_done"},    done,          0);
    endtask

    // One full scan: drive start/out_full per cycle, score every write
    task automatic run_scan(input string tag, input scen_t s);
        int   first  = -1;
        int   last   = -1;
        int   done_k = -1;
        int   n_wr   = 0;
        int   n_rd   = 0;
        int   rd_win = 0;
        int   wr_win = 0;
        exp_t e;
        fill_sb();
        for (int k = 0; k < BUDGET && done_k < 0; k++) begin
            @(posedge clock);
            #1;
            start    = (k == 0) || (k == s.restart_k);
            out_full = (k >= s.full_lo) && (k <= s.full_hi);
            @(negedge clock);
            if (accum_rd_en) begin
                chk({tag, "_rd_addr"}, accum_rd_addr, n_rd);
                n_rd++;
                if (k >= s.full_lo && k <= s.full_hi) rd_win++;
            end
            if (out_wr_en) begin
                chk({tag, "_wr_while_full"}, out_full, 0);
                if (k >= s.full_lo && k <= s.full_hi) wr_win++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_extra_word: got dout=%0d expected no write", tag, out_dout);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (out_dout !== 16'(e.data) || out_rho !== 16'(e.rho) ||
                        out_theta !== 8'(e.theta)) begin
                        failures++;
                        $display("FAIL %s_word: got dout=%0d rho=%0d theta=%0d expected dout=%0d rho=%0d theta=%0d",
                                 tag, out_dout, out_rho, out_theta, e.data, e.rho, e.theta);
                    end
                end
                if (first < 0) first = k;
                last = k;
                n_wr++;
            end
            if (done) begin
                done_k = k;
                chk({tag, "_busy_at_done"}, busy, 0);
            end
        end
        start    = 1'b0;
        out_full = 1'b0;
        chk({tag, "_first_wr_cycle"}, first,  s.exp_first);
        chk({tag, "_last_wr_cycle"},  last,   s.exp_last);
        chk({tag, "_done_cycle"},     done_k, s.exp_done);
        chk({tag, "_n_writes"},       n_wr,   NWORDS);
        chk({tag, "_n_reads"},        n_rd,   NWORDS);
        chk({tag, "_rd_in_stall"},    rd_win, s.exp_rd_win);
        chk({tag, "_wr_in_stall"},    wr_win, 0);
        chk({tag, "_sb_left"},        sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_wr;
        int n_rd;
        int n_busy;

        //                 lo  hi  rst first last done rdwin
        scen[0] = '{ -1, -1, -1,  3, 14, 15, 0 };   // free-running
        scen[1] = '{  5,  9, -1,  3, 19, 20, 0 };   // mid-scan stall
        scen[2] = '{  0,  9, -1, 10, 21, 22, 2 };   // full from start
        scen[3] = '{ -1, -1,  6,  3, 14, 15, 0 };   // stray start ignored

        reset    = 1'b0;
        start    = 1'b0;
        out_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clock);

        run_scan("nostall", scen[0]);
        run_scan("stall5_9", scen[1]);
        run_scan("fullstart", scen[2]);
        run_scan("restart6", scen[3]);

        // Reset asserted mid-scan at cycle 6 aborts everything immediately
        for (int k = 0; k <= 6; k++) begin
            @(posedge clock);
            #1;
            start = (k == 0);
        end
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        n_wr   = 0;
        n_rd   = 0;
        n_busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (out_wr_en)   n_wr++;
            if (accum_rd_en) n_rd++;
            if (busy)        n_busy++;
        end
        chk("postreset_writes", n_wr,   0);
        chk("postreset_reads",  n_rd,   0);
        chk("postreset_busy",   n_busy, 0);

        run_scan("afterreset", scen[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
